wb_bus_monitor: RTL and testbench
=================================

WB_BUS_MONITOR -- requirements
Module: wb_bus_monitor

Interface
REQ-001 Parameter AW, default 32, Wishbone address width.
REQ-002 Parameter DW, default 32, Wishbone data width.
REQ-003 Parameter DEPTH, default 4, capture FIFO depth; power of 2, minimum 2.
REQ-004 Parameter TIMEOUT, default 1024, stall cycles before the bus is declared hung.
REQ-005 Parameter ADDR_BASE, default 0, and ADDR_MASK, default 0, form the capture filter; a mask of 0 captures all addresses.
REQ-006 wb_clk  input  1  single clock; all logic on its rising edge.
REQ-007 wb_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 clr  input  1  synchronous clear of counters and sticky flags.
REQ-009 wb_adr, wb_dat_w, wb_dat_r  input  AW/DW/DW  snooped address, write data, read data.
REQ-010 wb_we, wb_cyc, wb_stb, wb_ack, wb_err  input  1 each  snooped Wishbone classic controls.
REQ-011 mon_valid  output  1  capture record available.
REQ-012 mon_ready  input  1  consumer accepts the record.
REQ-013 mon_we, mon_err  output  1 each  record direction and error-termination flag.
REQ-014 mon_adr, mon_dat  output  AW/DW  record address and data.
REQ-015 txn_count, err_count  output  16 each  completed-transaction and error-termination counts.
REQ-016 overflow, timeout  output  1 each  sticky flags.

Function
REQ-017 A transaction completes on any rising edge with wb_cyc & wb_stb & (wb_ack | wb_err); each such edge is one transaction, so back-to-back acks yield one record each.
REQ-018 A completed transaction whose (wb_adr & ADDR_MASK) == ADDR_BASE is pushed as {wb_err, wb_we, wb_adr, wb_we ? wb_dat_w : wb_dat_r}.
REQ-019 Filtered-out transactions are still counted but never pushed.
REQ-020 A pushed record is presented on mon_* one cycle after the completion edge when the FIFO was empty; the monitor adds no bus wait states.
REQ-021 A record pops on an edge with mon_valid & mon_ready; mon_* hold stable while mon_valid & ~mon_ready.
REQ-022 When the FIFO is full, a push is accepted only if a pop occurs on the same edge.
REQ-023 When the FIFO is full without a simultaneous pop, the record is dropped, FIFO contents are unchanged, and overflow sets.
REQ-024 On the empty FIFO, a simultaneous push and pop (mon_valid low) acts as a push only.
REQ-025 The FIFO holds records in order; pointers are AW-independent, log2(DEPTH)+1 bits, and wrap modulo 2*DEPTH.
REQ-026 txn_count increments on every completion and wraps at 0xFFFF -> 0.
REQ-027 err_count increments on completions with wb_err and saturates at 0xFFFF.
REQ-028 The watchdog FSM has three states: IDLE, WAIT and HUNG.
REQ-029 Watchdog transition: IDLE -> WAIT on cyc&stb&~ack&~err, loading the stall counter with 1.
REQ-030 In WAIT, the stall counter increments each cycle cyc&stb&~ack&~err.
REQ-031 In WAIT, ack, err or ~(cyc&stb) return the FSM to IDLE and zero the counter.
REQ-032 In WAIT, counter == TIMEOUT moves the FSM to HUNG and sets timeout.
REQ-033 HUNG is left only by clr or reset, going to IDLE; bus activity in HUNG is still captured and counted.
REQ-034 clr zeroes txn_count, err_count, overflow and timeout, and forces the FSM to IDLE; FIFO contents are kept.
REQ-035 A completion coincident with clr leaves the counters at 0 but its record is still pushed.

Reset
REQ-036 Reset drives mon_valid=0, mon_we=0, mon_err=0, mon_adr=0, mon_dat=0, txn_count=0, err_count=0, overflow=0, timeout=0, FIFO empty, FSM IDLE.
REQ-037 Reset asserted mid-transaction discards all buffered records; a completion on the first edge after deassertion is captured normally.

Structure
REQ-038 The record field widths and the watchdog state encoding SHALL live in the shared wb_dsp include file.
REQ-039 The FIFO SHALL be a sub-module named wb_mon_fifo with push/pop/full/empty ports; the watchdog and counters stay in the top level.

Verification
REQ-040 Write 0xA5A5_0001 to 0x10 then read 0x10 returning 0xA5A5_0001 with mon_ready=1 -> two records {we=1,0x10,0xA5A50001}, {we=0,0x10,0xA5A50001}; txn_count=2.
REQ-041 mon_ready=0, 5 back-to-back writes with DEPTH=4 -> 4 records retained in order, overflow=1, txn_count=5; then mon_ready=1 drains exactly 4.
REQ-042 Hold stb with no ack, TIMEOUT=16 -> timeout rises at stall cycle 16; ack at cycle 10 in a second run -> no timeout.
REQ-043 ADDR_BASE=0x100, ADDR_MASK=0xF00; accesses to 0x104 and 0x204 -> one record (0x104), txn_count=2.
REQ-044 Termination with err on a read of 0x20 -> record mon_err=1, err_count=1; clr next cycle -> counters/flags 0 and the record is still poppable.
REQ-045 Full FIFO with simultaneous pop and completion -> record accepted and overflow stays 0; wb_rst_n low mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/wb_dsp_pkg.sv
// Shared record layout and watchdog state encoding for the Wishbone bus monitor.
package wb_dsp_pkg;

  // Per-record flag bits ahead of address and data: {err, we}.
  localparam int REC_FLAG_W = 2;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int WD_W = 2;
  localparam logic [WD_W-1:0] WD_IDLE = 2'd0;
  localparam logic [WD_W-1:0] WD_WAIT = 2'd1;
  localparam logic [WD_W-1:0] WD_HUNG = 2'd2;

  function automatic int rec_width(input int aw, input int dw);
    return REC_FLAG_W + aw + dw;
  endfunction

endpackage

// File: rtl/wb_mon_fifo.sv
// In-order capture FIFO; head is visible the cycle after the first push.
// Full without a same-edge pop refuses the push; a pop on empty is ignored.
module wb_mon_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/wb_bus_monitor.sv
// Passive Wishbone snooper: captures filtered completions, counts traffic, flags hung cycles.
// Records appear one cycle after completion; consumer stalls via mon_ready, overflow drops new records.
module wb_bus_monitor
  import wb_dsp_pkg::*;
#(
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter int          DEPTH     = 4,
  parameter int          TIMEOUT   = 1024,
  parameter logic [AW-1:0] ADDR_BASE = '0,
  parameter logic [AW-1:0] ADDR_MASK = '0
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          clr,
  input  logic [AW-1:0] wb_adr,
  input  logic [DW-1:0] wb_dat_w,
  input  logic [DW-1:0] wb_dat_r,
  input  logic          wb_we,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_ack,
  input  logic          wb_err,
  output logic          mon_valid,
  input  logic          mon_ready,
  output logic          mon_we,
  output logic          mon_err,
  output logic [AW-1:0] mon_adr,
  output logic [DW-1:0] mon_dat,
  output logic [15:0]   txn_count,
  output logic [15:0]   err_count,
  output logic          overflow,
  output logic          timeout
);

  localparam int RW = rec_width(AW, DW);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] TO_LIM = SW'(TIMEOUT);

  logic          completion;
  logic          stall;
  logic          addr_hit;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [RW-1:0] push_rec;
  logic [RW-1:0] head_rec;

  logic [WD_W-1:0] wd_state;
  logic [SW-1:0]   stall_cnt;
  logic [SW-1:0]   stall_cnt_inc;

  assign completion = wb_cyc & wb_stb & (wb_ack | wb_err);
  assign stall      = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
  assign addr_hit   = ((wb_adr & ADDR_MASK) == ADDR_BASE);
  assign push       = completion & addr_hit;
  assign pop        = mon_valid & mon_ready;
  assign push_rec   = {wb_err, wb_we, wb_adr, (wb_we ? wb_dat_w : wb_dat_r)};

  wb_mon_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (wb_clk),
    .rst_n    (wb_rst_n),
    .push     (push),
    .push_dat (push_rec),
    .pop      (pop),
    .pop_dat  (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // FIFO storage is not reset, so the record fields are masked while empty.
  assign mon_valid = ~fifo_empty;
  assign mon_err   = mon_valid & head_rec[RW-1];
  assign mon_we    = mon_valid & head_rec[RW-2];
  assign mon_adr   = mon_valid ? head_rec[AW+DW-1:DW] : '0;
  assign mon_dat   = mon_valid ? head_rec[DW-1:0] : '0;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      txn_count <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      txn_count <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (completion) begin
        txn_count <= txn_count + 1'b1;
        if (wb_err && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign stall_cnt_inc = stall_cnt + SW'(1);

  // The counter holds the number of consecutive stalled edges seen so far.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wd_state  <= WD_IDLE;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else if (clr) begin
      wd_state  <= WD_IDLE;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      case (wd_state)
        WD_IDLE: begin
          if (stall) begin
            stall_cnt <= SW'(1);
            if (TO_LIM == SW'(1)) begin
              wd_state <= WD_HUNG;
              timeout  <= 1'b1;
            end else begin
              wd_state <= WD_WAIT;
            end
          end
        end
        WD_WAIT: begin
          if (!stall) begin
            wd_state  <= WD_IDLE;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt_inc;
            if (stall_cnt_inc == TO_LIM) begin
              wd_state <= WD_HUNG;
              timeout  <= 1'b1;
            end
          end
        end
        WD_HUNG: wd_state <= WD_HUNG;
        default: begin
          wd_state  <= WD_IDLE;
          stall_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_monitor.sv
// Directed bench for wb_bus_monitor: one unfiltered instance and one address-filtered instance.
module tb_wb_bus_monitor;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat_w = '0;
  logic [31:0] wb_dat_r = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        mon_ready = 1'b0;

  logic        mon_valid, mon_we, mon_err, overflow, timeout;
  logic [31:0] mon_adr, mon_dat;
  logic [15:0] txn_count, err_count;

  logic        mon_valid_f, mon_we_f, mon_err_f, overflow_f, timeout_f;
  logic [31:0] mon_adr_f, mon_dat_f;
  logic [15:0] txn_count_f, err_count_f;

  int checks = 0;
  int failures = 0;

  always #5 wb_clk = ~wb_clk;

  wb_bus_monitor #(
    .AW(32), .DW(32), .DEPTH(4), .TIMEOUT(16), .ADDR_BASE(32'h0), .ADDR_MASK(32'h0)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .clr(clr),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack), .wb_err(wb_err),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_we(mon_we), .mon_err(mon_err),
    .mon_adr(mon_adr), .mon_dat(mon_dat), .txn_count(txn_count), .err_count(err_count),
    .overflow(overflow), .timeout(timeout)
  );

  wb_bus_monitor #(
    .AW(32), .DW(32), .DEPTH(4), .TIMEOUT(16), .ADDR_BASE(32'h100), .ADDR_MASK(32'hF00)
  ) dut_f (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .clr(clr),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack), .wb_err(wb_err),
    .mon_valid(mon_valid_f), .mon_ready(mon_ready), .mon_we(mon_we_f), .mon_err(mon_err_f),
    .mon_adr(mon_adr_f), .mon_dat(mon_dat_f), .txn_count(txn_count_f), .err_count(err_count_f),
    .overflow(overflow_f), .timeout(timeout_f)
  );

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic bus_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_we = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle();
    clr = 1'b0;
    mon_ready = 1'b0;
    wb_rst_n = 1'b0;
    step();
    step();
    wb_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mon_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", mon_valid); end
    checks++; if (mon_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", mon_we); end
    checks++; if (mon_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", mon_err); end
    checks++; if (mon_adr !== 32'h0) begin failures++; $display("FAIL rst_adr got=%0h exp=0", mon_adr); end
    checks++; if (mon_dat !== 32'h0) begin failures++; $display("FAIL rst_dat got=%0h exp=0", mon_dat); end
    checks++; if (txn_count !== 16'h0) begin failures++; $display("FAIL rst_txn got=%0h exp=0", txn_count); end
    checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL rst_errcnt got=%0h exp=0", err_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0h exp=0", overflow); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%0h exp=0", timeout); end
  endtask

  task automatic test_write_read();
    do_reset();
    mon_ready = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1; wb_we = 1'b1;
    wb_adr = 32'h10; wb_dat_w = 32'hA5A5_0001; wb_dat_r = 32'h0;
    step();
    checks++; if (mon_valid !== 1'b1) begin failures++; $display("FAIL wr_valid got=%0h exp=1", mon_valid); end
    checks++; if (mon_we !== 1'b1) begin failures++; $display("FAIL wr_we got=%0h exp=1", mon_we); end
    checks++; if (mon_adr !== 32'h10) begin failures++; $display("FAIL wr_adr got=%0h exp=10", mon_adr); end
    checks++; if (mon_dat !== 32'hA5A5_0001) begin failures++; $display("FAIL wr_dat got=%0h exp=a5a50001", mon_dat); end
    wb_we = 1'b0; wb_dat_w = 32'h0; wb_dat_r = 32'hA5A5_0001;
    step();
    checks++; if (mon_valid !== 1'b1) begin failures++; $display("FAIL rd_valid got=%0h exp=1", mon_valid); end
    checks++; if (mon_we !== 1'b0) begin failures++; $display("FAIL rd_we got=%0h exp=0", mon_we); end
    checks++; if (mon_adr !== 32'h10) begin failures++; $display("FAIL rd_adr got=%0h exp=10", mon_adr); end
    checks++; if (mon_dat !== 32'hA5A5_0001) begin failures++; $display("FAIL rd_dat got=%0h exp=a5a50001", mon_dat); end
    bus_idle();
    step();
    checks++; if (mon_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_drained got=%0h exp=0", mon_valid); end
    checks++; if (txn_count !== 16'd2) begin failures++; $display("FAIL wr_rd_txn got=%0d exp=2", txn_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1; wb_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wb_adr = 32'h40 + 32'(4 * i);
      wb_dat_w = 32'h1000 + 32'(i);
      step();
    end
    bus_idle();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
    checks++; if (txn_count !== 16'd5) begin failures++; $display("FAIL ovf_txn got=%0d exp=5", txn_count); end
    checks++; if (mon_adr !== 32'h40) begin failures++; $display("FAIL ovf_head_hold got=%0h exp=40", mon_adr); end
    mon_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mon_valid !== 1'b1) begin failures++; $display("FAIL ovf_drain_valid[%0d] got=%0h exp=1", i, mon_valid); end
      checks++; if (mon_adr !== 32'h40 + 32'(4 * i)) begin failures++; $display("FAIL ovf_drain_adr[%0d] got=%0h exp=%0h", i, mon_adr, 32'h40 + 32'(4 * i)); end
      checks++; if (mon_dat !== 32'h1000 + 32'(i)) begin failures++; $display("FAIL ovf_drain_dat[%0d] got=%0h exp=%0h", i, mon_dat, 32'h1000 + 32'(i)); end
      step();
    end
    checks++; if (mon_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain_empty got=%0h exp=0", mon_valid); end
  endtask

  task automatic test_timeout();
    do_reset();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h50;
    repeat (15) step();
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_stall15 got=%0h exp=0", timeout); end
    step();
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_stall16 got=%0h exp=1", timeout); end
    bus_idle();
    repeat (3) step();
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0h exp=1", timeout); end
    checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL to_txn got=%0d exp=0", txn_count); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_clr got=%0h exp=0", timeout); end
    wb_cyc = 1'b1; wb_stb = 1'b1;
    repeat (9) step();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    repeat (10) step();
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_ack_restart got=%0h exp=0", timeout); end
    bus_idle();
    step();
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL to_ack_txn got=%0d exp=1", txn_count); end
  endtask

  task automatic test_filter();
    do_reset();
    mon_ready = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1; wb_we = 1'b1;
    wb_adr = 32'h104; wb_dat_w = 32'h11;
    step();
    checks++; if (mon_valid_f !== 1'b1) begin failures++; $display("FAIL flt_valid got=%0h exp=1", mon_valid_f); end
    checks++; if (mon_adr_f !== 32'h104) begin failures++; $display("FAIL flt_adr got=%0h exp=104", mon_adr_f); end
    checks++; if (mon_dat_f !== 32'h11) begin failures++; $display("FAIL flt_dat got=%0h exp=11", mon_dat_f); end
    wb_adr = 32'h204; wb_dat_w = 32'h22;
    step();
    bus_idle();
    checks++; if (mon_valid_f !== 1'b0) begin failures++; $display("FAIL flt_reject got=%0h exp=0", mon_valid_f); end
    checks++; if (txn_count_f !== 16'd2) begin failures++; $display("FAIL flt_txn got=%0d exp=2", txn_count_f); end
    checks++; if (mon_adr !== 32'h204) begin failures++; $display("FAIL nofilter_adr got=%0h exp=204", mon_adr); end
  endtask

  task automatic test_err_clr();
    do_reset();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_err = 1'b1; wb_we = 1'b0;
    wb_adr = 32'h20; wb_dat_r = 32'hDEAD_0020;
    step();
    bus_idle();
    checks++; if (mon_err !== 1'b1) begin failures++; $display("FAIL err_flag got=%0h exp=1", mon_err); end
    checks++; if (mon_we !== 1'b0) begin failures++; $display("FAIL err_we got=%0h exp=0", mon_we); end
    checks++; if (mon_adr !== 32'h20) begin failures++; $display("FAIL err_adr got=%0h exp=20", mon_adr); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL err_cnt got=%0d exp=1", err_count); end
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL err_txn got=%0d exp=1", txn_count); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL clr_txn got=%0d exp=0", txn_count); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clr_errcnt got=%0d exp=0", err_count); end
    checks++; if (mon_valid !== 1'b1) begin failures++; $display("FAIL clr_keeps_rec got=%0h exp=1", mon_valid); end
    checks++; if (mon_adr !== 32'h20) begin failures++; $display("FAIL clr_rec_adr got=%0h exp=20", mon_adr); end
    clr = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1; wb_we = 1'b1;
    wb_adr = 32'h30; wb_dat_w = 32'h3;
    step();
    clr = 1'b0;
    bus_idle();
    checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL clr_comp_txn got=%0d exp=0", txn_count); end
    mon_ready = 1'b1;
    step();
    checks++; if (mon_adr !== 32'h30) begin failures++; $display("FAIL clr_comp_rec got=%0h exp=30", mon_adr); end
    checks++; if (mon_err !== 1'b0) begin failures++; $display("FAIL clr_comp_err got=%0h exp=0", mon_err); end
    step();
    checks++; if (mon_valid !== 1'b0) begin failures++; $display("FAIL clr_drained got=%0h exp=0", mon_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1; wb_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_adr = 32'h80 + 32'(4 * i);
      wb_dat_w = 32'h2000 + 32'(i);
      step();
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_full_ovf got=%0h exp=0", overflow); end
    mon_ready = 1'b1;
    wb_adr = 32'h90; wb_dat_w = 32'h2004;
    step();
    bus_idle();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_pushpop_ovf got=%0h exp=0", overflow); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (mon_adr !== 32'h80 + 32'(4 * i)) begin failures++; $display("FAIL b2b_adr[%0d] got=%0h exp=%0h", i, mon_adr, 32'h80 + 32'(4 * i)); end
      checks++; if (mon_dat !== 32'h2000 + 32'(i)) begin failures++; $display("FAIL b2b_dat[%0d] got=%0h exp=%0h", i, mon_dat, 32'h2000 + 32'(i)); end
      step();
    end
    checks++; if (mon_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0h exp=0", mon_valid); end
    mon_ready = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1; wb_we = 1'b1;
    wb_adr = 32'hC0; wb_dat_w = 32'h5;
    step();
    step();
    wb_rst_n = 1'b0;
    #1;
    checks++; if (mon_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0h exp=0", mon_valid); end
    checks++; if (mon_adr !== 32'h0) begin failures++; $display("FAIL arst_adr got=%0h exp=0", mon_adr); end
    checks++; if (mon_dat !== 32'h0) begin failures++; $display("FAIL arst_dat got=%0h exp=0", mon_dat); end
    checks++; if (mon_we !== 1'b0) begin failures++; $display("FAIL arst_we got=%0h exp=0", mon_we); end
    checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL arst_txn got=%0d exp=0", txn_count); end
    bus_idle();
    step();
    wb_rst_n = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1; wb_we = 1'b1;
    wb_adr = 32'hA0; wb_dat_w = 32'h6;
    step();
    bus_idle();
    checks++; if (mon_adr !== 32'hA0) begin failures++; $display("FAIL post_rst_adr got=%0h exp=a0", mon_adr); end
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL post_rst_txn got=%0d exp=1", txn_count); end
    mon_ready = 1'b1;
    step();
    checks++; if (mon_valid !== 1'b0) begin failures++; $display("FAIL post_rst_discard got=%0h exp=0", mon_valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_overflow();
    test_timeout();
    test_filter();
    test_err_clr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
